uart_prog_loader: RTL and testbench

Parametrised successor to the fixed 3-byte UART program loader. It takes the byte stream from the UART receiver and assembles words of configurable width, little-endian (first byte is the LSB). It frames a program between configurable start and stop words, writes each program word into instruction memory at an auto-incrementing address, and holds the CPU while loading. It adds behaviour the old loader lacked: an inter-byte timeout with realignment, sticky overflow and timeout error flags, a stop-with-reset versus stop-and-run choice, and a word count.

---
 rtl/uart_prog_loader_pkg.sv | 18 +
 rtl/uart_prog_loader_if.sv | 27 ++
 rtl/uart_prog_loader_assembler.sv | 65 ++++++
 rtl/uart_prog_loader.sv | 118 +++++++++++
 tb/tb_uart_prog_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared types, default framing words and width helper for the program loader
package prog_loader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Framing words of the 24-bit ISA
    localparam logic [23:0] DEFAULT_START_WORD    = 24'hFF0000;
    localparam logic [23:0] DEFAULT_STOP_RST_WORD = 24'hFFFF00;
    localparam logic [23:0] DEFAULT_STOP_RUN_WORD = 24'hFFF000;

    function automatic int word_width(input int bytes_per_word);
        return 8 * bytes_per_word;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - receive byte stream and instruction memory write bus of the program loader
interface uart_prog_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int W          = 24
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [W-1:0]          imem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/uart_prog_loader_assembler.sv
// rtl/uart_prog_loader_assembler.sv - little-endian word assembly with byte counter and inter-byte timeout
module word_assembler
    import prog_loader_pkg::*;
#(
    parameter int BYTES_PER_WORD = 3,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int W             = word_width(BYTES_PER_WORD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         aligned,
    input  logic         realign,
    output logic [W-1:0] window_next,
    output logic         word_done,
    output logic         timeout
);

    localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0]  window;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          last_byte;

    if (W > 8) begin : g_shift
        assign window_next = {rx_data, window[W-1:8]};
    end else begin : g_single
        assign window_next = rx_data;
    end

    assign last_byte = (byte_cnt == CW'(BYTES_PER_WORD - 1));
    // In sliding mode every byte closes a candidate word
    assign word_done = rx_valid && (!aligned || last_byte);
    // A byte arriving on the expiry cycle wins over the timeout
    assign timeout   = aligned && !rx_valid && (byte_cnt != '0) &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window   <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (rx_valid) begin
                window <= window_next;
            end

            if (realign || timeout) begin
                byte_cnt <= '0;
            end else if (rx_valid) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            end

            if (rx_valid || timeout || !aligned || (byte_cnt == '0)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - framed UART program loader writing instruction memory and holding the CPU
module uart_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int BYTES_PER_WORD                    = 3,
    parameter int ADDR_WIDTH                        = 8,
    parameter int TIMEOUT_CYCLES                    = 100000,
    parameter logic [8*BYTES_PER_WORD-1:0] START_WORD    = DEFAULT_START_WORD,
    parameter logic [8*BYTES_PER_WORD-1:0] STOP_RST_WORD = DEFAULT_STOP_RST_WORD,
    parameter logic [8*BYTES_PER_WORD-1:0] STOP_RUN_WORD = DEFAULT_STOP_RUN_WORD
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_prog_loader_if.master      bus,
    output logic                    cpu_hold,
    output logic                    cpu_rst_pulse,
    output logic                    loading,
    output logic [ADDR_WIDTH:0]     word_count,
    output logic                    err_overflow,
    output logic                    err_timeout
);

    localparam int W = word_width(BYTES_PER_WORD);

    if (BYTES_PER_WORD < 1) begin : g_bad_width
        $error("uart_prog_loader: BYTES_PER_WORD must be at least 1");
    end
    if ((START_WORD == STOP_RST_WORD) || (START_WORD == STOP_RUN_WORD) ||
        (STOP_RST_WORD == STOP_RUN_WORD)) begin : g_bad_framing
        $error("uart_prog_loader: framing words must be distinct");
    end

    state_t       state;
    logic [W-1:0] window_next;
    logic         word_done;
    logic         timeout;
    logic         start_seen;

    assign start_seen = word_done && (window_next == START_WORD);

    word_assembler #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_assembler (
        .clk         (clk),
        .rst_n       (rst),
        .rx_data     (bus.rx_data),
        .rx_valid    (bus.rx_valid),
        .aligned     (state == LOAD),
        .realign     (start_seen && (state == IDLE)),
        .window_next (window_next),
        .word_done   (word_done),
        .timeout     (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b0;
            cpu_rst_pulse  <= 1'b0;
            loading        <= 1'b0;
            word_count     <= '0;
            err_overflow   <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            bus.imem_we   <= 1'b0;
            cpu_rst_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_seen) begin
                        state         <= LOAD;
                        bus.imem_addr <= '0;
                        word_count    <= '0;
                        err_overflow  <= 1'b0;
                        err_timeout   <= 1'b0;
                        cpu_hold      <= 1'b1;
                        loading       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (timeout) begin
                        err_timeout <= 1'b1;
                    end
                    if (word_done) begin
                        if (window_next == START_WORD) begin
                            bus.imem_addr <= '0;
                            word_count    <= '0;
                            err_overflow  <= 1'b0;
                            err_timeout   <= 1'b0;
                        end else if (window_next == STOP_RST_WORD) begin
                            state         <= IDLE;
                            cpu_hold      <= 1'b0;
                            loading       <= 1'b0;
                            cpu_rst_pulse <= 1'b1;
                        end else if (window_next == STOP_RUN_WORD) begin
                            state    <= IDLE;
                            cpu_hold <= 1'b0;
                            loading  <= 1'b0;
                        end else if (!word_count[ADDR_WIDTH]) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= word_count[ADDR_WIDTH-1:0];
                            bus.imem_wdata <= window_next;
                            word_count     <= word_count + 1'b1;
                        end else begin
                            // Memory full: drop the word, never wrap the address
                            err_overflow <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench with a write scoreboard for uart_prog_loader
module tb_uart_prog_loader;

    localparam int AW  = 2;
    localparam int BPW = 3;
    localparam int W   = 24;
    localparam int TMO = 20;

    logic          clk;
    logic          rst;
    logic          cpu_hold;
    logic          cpu_rst_pulse;
    logic          loading;
    logic [AW:0]   word_count;
    logic          err_overflow;
    logic          err_timeout;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;
    logic prev_pulse = 1'b0;

    uart_prog_loader_if #(.ADDR_WIDTH(AW), .W(W)) bus ();

    uart_prog_loader #(
        .BYTES_PER_WORD (BPW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .cpu_rst_pulse (cpu_rst_pulse),
        .loading       (loading),
        .word_count    (word_count),
        .err_overflow  (err_overflow),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [23:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst) begin
            if (bus.imem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {31'b0, bus.imem_we}, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(bus.imem_addr), e.addr);
                    check("write_data", 32'(bus.imem_wdata), e.data);
                end
            end
            if (prev_pulse) check("rst_pulse_width", {31'b0, cpu_rst_pulse}, 32'd0);
            if (cpu_rst_pulse) pulse_cnt++;
            prev_pulse = cpu_rst_pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},      {31'b0, bus.imem_we}, 32'd0);
        check({tag, "_addr"},    32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"},   32'(bus.imem_wdata), 32'd0);
        check({tag, "_hold"},    {31'b0, cpu_hold}, 32'd0);
        check({tag, "_pulse"},   {31'b0, cpu_rst_pulse}, 32'd0);
        check({tag, "_loading"}, {31'b0, loading}, 32'd0);
        check({tag, "_wcount"},  32'(word_count), 32'd0);
        check({tag, "_ovf"},     {31'b0, err_overflow}, 32'd0);
        check({tag, "_tmo"},     {31'b0, err_timeout}, 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle_cycles(3);
        check_outputs_zero("reset");
        rst = 1'b1;
        idle_cycles(2);

        // Basic frame terminated by stop-with-reset
        pulse_cnt = 0;
        send_word(24'hFF0000);
        check("t1_hold_after_start", {31'b0, cpu_hold}, 32'd1);
        check("t1_loading_after_start", {31'b0, loading}, 32'd1);
        expect_write(0, 32'h800110);
        send_word(24'h800110);
        expect_write(1, 32'hB01000);
        send_word(24'hB01000);
        send_word(24'hFFFF00);
        idle_cycles(2);
        check("t1_pulses", 32'(pulse_cnt), 32'd1);
        check("t1_wcount", 32'(word_count), 32'd2);
        check("t1_hold", {31'b0, cpu_hold}, 32'd0);
        check("t1_loading", {31'b0, loading}, 32'd0);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // Garbage before start, sliding match, stop-and-run
        pulse_cnt = 0;
        send_byte(8'h12);
        send_byte(8'h34);
        send_word(24'hFF0000);
        check("t2_loading", {31'b0, loading}, 32'd1);
        expect_write(0, 32'h800105);
        send_word(24'h800105);
        send_word(24'hFFF000);
        idle_cycles(2);
        check("t2_pulses", 32'(pulse_cnt), 32'd0);
        check("t2_hold", {31'b0, cpu_hold}, 32'd0);
        check("t2_wcount", 32'(word_count), 32'd1);
        check("t2_pending", 32'(exp_q.size()), 32'd0);

        // Inter-byte timeout discards the partial word and realigns
        send_word(24'hFF0000);
        send_byte(8'h06);
        send_byte(8'h00);
        idle_cycles(TMO + 5);
        check("t3_tmo_flag", {31'b0, err_timeout}, 32'd1);
        check("t3_still_loading", {31'b0, loading}, 32'd1);
        expect_write(0, 32'hF00006);
        send_word(24'hF00006);
        send_word(24'hFFF000);
        idle_cycles(2);
        check("t3_tmo_sticky", {31'b0, err_timeout}, 32'd1);
        check("t3_wcount", 32'(word_count), 32'd1);
        check("t3_pending", 32'(exp_q.size()), 32'd0);

        // Overflow with a 4-word memory
        send_word(24'hFF0000);
        check("t4_tmo_cleared", {31'b0, err_timeout}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_write(32'(i - 1), 32'(i));
            send_word(24'(i));
        end
        idle_cycles(1);
        check("t4_ovf", {31'b0, err_overflow}, 32'd1);
        check("t4_wcount", 32'(word_count), 32'd4);
        send_word(24'hFFF000);
        idle_cycles(2);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // Restart mid-frame returns to address 0 and clears errors
        send_word(24'hFF0000);
        check("t5_ovf_cleared", {31'b0, err_overflow}, 32'd0);
        expect_write(0, 32'h332211);
        send_word(24'h332211);
        send_word(24'hFF0000);
        expect_write(0, 32'h665544);
        send_word(24'h665544);
        send_word(24'hFFF000);
        idle_cycles(2);
        check("t5_wcount", 32'(word_count), 32'd1);
        check("t5_pending", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a partial word
        pulse_cnt = 0;
        send_word(24'hFF0000);
        send_byte(8'h01);
        send_byte(8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        idle_cycles(3);
        rst = 1'b1;
        idle_cycles(2);
        check("t6_no_pulse", 32'(pulse_cnt), 32'd0);
        send_word(24'hFF0000);
        idle_cycles(TMO + 10);
        check("t6_no_false_tmo", {31'b0, err_timeout}, 32'd0);
        expect_write(0, 32'hF00001);
        send_word(24'hF00001);
        send_word(24'hFFFF00);
        idle_cycles(2);
        check("t6_pulses", 32'(pulse_cnt), 32'd1);
        check("t6_wcount", 32'(word_count), 32'd1);
        check("t6_tmo_final", {31'b0, err_timeout}, 32'd0);
        check("t6_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
